// File: rtl/gpio_port.sv
// GPIO peripheral: output/enable registers, synchronised and optionally debounced
// inputs, and a level interrupt on enabled rising/falling edges.

module gpio_pin #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic filt
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign s = sync_q[SYNC_STAGES-1];

    if (DEB_CYCLES == 0) begin : g_nodeb
        assign filt = s;
    end else begin : g_deb
        localparam int CW = $clog2(DEB_CYCLES + 1);
        logic [CW-1:0] cnt_q, cnt_d;
        logic          f_q, f_d;

        // The filter flips on the edge where the count would reach DEB_CYCLES.
        always_comb begin
            cnt_d = '0;
            f_d   = f_q;
            if (s != f_q) begin
                if (cnt_q == CW'(DEB_CYCLES - 1)) f_d = s;
                else                              cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                f_q   <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                f_q   <= f_d;
            end
        end

        assign filt = f_q;
    end
endmodule

module gpio_port #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       addr,
    input  logic [15:0]      wdata,
    input  logic             wr,
    input  logic             rd,
    output logic [15:0]      rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [2:0] A_OUT = 3'd0, A_OE = 3'd1, A_IN = 3'd2, A_SET = 3'd3,
                           A_CLR = 3'd4, A_RIE = 3'd5, A_FIE = 3'd6, A_STAT = 3'd7;

    logic [WIDTH-1:0] out_q, out_d, oe_q, oe_d, rie_q, rie_d, fie_q, fie_d;
    logic [WIDTH-1:0] stat_q, stat_d, f_q, filt, wd, stat_clr, rise, fall, rsel;
    logic [15:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    gpio_pin #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_pin [WIDTH-1:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (gpio_in),
        .filt   (filt)
    );

    assign wd = wdata[WIDTH-1:0];

    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        rie_d    = rie_q;
        fie_d    = fie_q;
        stat_clr = '0;
        if (wr) begin
            case (addr)
                A_OUT:   out_d    = wd;
                A_OE:    oe_d     = wd;
                A_SET:   out_d    = out_q | wd;
                A_CLR:   out_d    = out_q & ~wd;
                A_RIE:   rie_d    = wd;
                A_FIE:   fie_d    = wd;
                A_STAT:  stat_clr = wd;
                default: ;
            endcase
        end

        rise = filt & ~f_q;
        fall = ~filt & f_q;
        // New events are ORed in after the clear so a same-cycle set wins.
        stat_d = (stat_q & ~stat_clr) | (rise & rie_q) | (fall & fie_q);
        irq_d  = |stat_q;

        case (addr)
            A_OUT:   rsel = out_q;
            A_OE:    rsel = oe_q;
            A_IN:    rsel = filt;
            A_RIE:   rsel = rie_q;
            A_FIE:   rsel = fie_q;
            A_STAT:  rsel = stat_q;
            default: rsel = '0;
        endcase
        rdata_d = rd ? 16'(rsel) : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            oe_q    <= '0;
            rie_q   <= '0;
            fie_q   <= '0;
            stat_q  <= '0;
            f_q     <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            oe_q    <= oe_d;
            rie_q   <= rie_d;
            fie_q   <= fie_d;
            stat_q  <= stat_d;
            f_q     <= filt;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;
    assign rdata    = rdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_gpio_port.sv
// Directed bench: one gpio_port without debounce (dut0), one with DEB_CYCLES=4 (dut4).

module tb_gpio_port;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic        wr, rd;
    logic [7:0]  gpio_in0, gpio_in4, gpio_out0, gpio_out4, gpio_oe0, gpio_oe4;
    logic [15:0] rdata0, rdata4;
    logic        irq0, irq4;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    gpio_port #(.WIDTH(8), .SYNC_STAGES(2), .DEB_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wr(wr), .rd(rd),
        .rdata(rdata0), .gpio_in(gpio_in0), .gpio_out(gpio_out0), .gpio_oe(gpio_oe0),
        .irq(irq0)
    );

    gpio_port #(.WIDTH(8), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wr(wr), .rd(rd),
        .rdata(rdata4), .gpio_in(gpio_in4), .gpio_out(gpio_out4), .gpio_oe(gpio_oe4),
        .irq(irq4)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk);
        #1 wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a);
        addr = a; rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0;
        gpio_in0 = 8'hFF; gpio_in4 = 8'hFF;

        // Reset values, pins held high through release
        #12;
        chk("rst_out0", 16'(gpio_out0), 16'h0);
        chk("rst_oe0", 16'(gpio_oe0), 16'h0);
        chk("rst_irq0", 16'(irq0), 16'h0);
        chk("rst_rdata0", rdata0, 16'h0);
        chk("rst_out4", 16'(gpio_out4), 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(10);
        wr_reg(3'd5, 16'h00FF);
        tick(3);
        chk("post_rst_irq0", 16'(irq0), 16'h0);
        chk("post_rst_irq4", 16'(irq4), 16'h0);
        rd_reg(3'd7);
        chk("post_rst_stat0", rdata0, 16'h0);
        chk("post_rst_stat4", rdata4, 16'h0);
        rd_reg(3'd5);
        chk("rie_rd", rdata0, 16'h00FF);
        gpio_in0 = 8'h00; gpio_in4 = 8'h00;
        tick(12);

        // OUT / OE / SET / CLR
        chk("out_pre", 16'(gpio_out0), 16'h0);
        wr_reg(3'd0, 16'h00A5);
        chk("out_a5", 16'(gpio_out0), 16'h00A5);
        wr_reg(3'd1, 16'h000F);
        chk("oe_0f", 16'(gpio_oe0), 16'h000F);
        wr_reg(3'd3, 16'h0010);
        chk("set_10", 16'(gpio_out0), 16'h00B5);
        wr_reg(3'd4, 16'h0001);
        chk("clr_01", 16'(gpio_out0), 16'h00B4);
        rd_reg(3'd0);
        chk("rd_out", rdata0, 16'h00B4);
        rd_reg(3'd3);
        chk("rd_set", rdata0, 16'h0);
        addr = 3'd0; wdata = 16'h003C; wr = 1'b1; rd = 1'b1;
        @(posedge clk);
        #1 wr = 1'b0; rd = 1'b0;
        chk("rdwr_prewrite", rdata0, 16'h00B4);
        chk("rdwr_out", 16'(gpio_out0), 16'h003C);

        // Rising edge on pin2, no debounce
        wr_reg(3'd5, 16'h0004);
        gpio_in0[2] = 1'b1;
        tick(3);
        chk("rise_irq_early", 16'(irq0), 16'h0);
        rd_reg(3'd7);
        chk("rise_stat", rdata0, 16'h0004);
        chk("rise_irq", 16'(irq0), 16'h1);
        wr_reg(3'd7, 16'h0004);
        rd_reg(3'd7);
        chk("w1c_stat", rdata0, 16'h0);
        chk("w1c_irq", 16'(irq0), 16'h0);
        rd_reg(3'd2);
        chk("in0", rdata0, 16'h0004);

        // Debounce: 3-cycle glitch rejected, held level accepted after 2+4
        wr_reg(3'd5, 16'h0005);
        gpio_in4[0] = 1'b1;
        tick(3);
        gpio_in4[0] = 1'b0;
        tick(10);
        rd_reg(3'd2);
        chk("glitch_in4", rdata4, 16'h0);
        rd_reg(3'd7);
        chk("glitch_stat4", rdata4, 16'h0);
        gpio_in4[0] = 1'b1;
        tick(5);
        rd_reg(3'd2);
        chk("deb_in4_early", rdata4, 16'h0);
        rd_reg(3'd2);
        chk("deb_in4", rdata4, 16'h0001);
        rd_reg(3'd7);
        chk("deb_stat4", rdata4, 16'h0001);
        chk("deb_irq4", 16'(irq4), 16'h1);
        wr_reg(3'd7, 16'h0001);

        // Falling edge on pin7 collides with a STAT clear: set wins
        gpio_in0[7] = 1'b1;
        tick(6);
        wr_reg(3'd6, 16'h0080);
        gpio_in0[7] = 1'b0;
        tick(2);
        wr_reg(3'd7, 16'h0080);
        rd_reg(3'd7);
        chk("fall_set_wins", rdata0, 16'h0080);
        wr_reg(3'd6, 16'h0000);
        rd_reg(3'd7);
        chk("ie_off_keeps", rdata0, 16'h0080);
        wr_reg(3'd7, 16'h0080);
        rd_reg(3'd7);
        chk("fall_cleared", rdata0, 16'h0);

        // Asynchronous reset mid-debounce
        wr_reg(3'd0, 16'h00FF);
        wr_reg(3'd1, 16'h00FF);
        wr_reg(3'd5, 16'h00FF);
        gpio_in0 = 8'hFF; gpio_in4 = 8'hFF;
        tick(5);
        chk("pre_arst_irq0", 16'(irq0), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out0", 16'(gpio_out0), 16'h0);
        chk("arst_oe0", 16'(gpio_oe0), 16'h0);
        chk("arst_irq0", 16'(irq0), 16'h0);
        chk("arst_out4", 16'(gpio_out4), 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd_reg(3'd2);
        chk("arst_in0", rdata0, 16'h0);
        chk("arst_in4", rdata4, 16'h0);
        tick(10);
        rd_reg(3'd2);
        chk("resync_in0", rdata0, 16'h00FF);
        chk("resync_in4", rdata4, 16'h00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
